cavlc_sync_fifo: RTL and testbench

- Parametrised single-clock FIFO: width, depth and flag thresholds are parameters.
- Replaces the fixed 8x16 coefficient buffer memory in the CAVLC datapath.
- Owns its own read/write pointers, occupancy count, full/empty/almost flags and a registered read port with a valid strobe.
- Adds synchronous flush and sticky overflow/underflow error flags.
- Sits between the coefficient scan stage (writer) and the CAVLC encoder core (reader).

---
 rtl/cavlc_sync_fifo.sv | 106 ++++++++++
 tb/tb_cavlc_sync_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cavlc_sync_fifo.sv
// Single-clock FIFO between the coefficient scan stage and the CAVLC encoder core.
// Registered read port with valid strobe, synchronous flush and sticky error flags.
module cavlc_sync_fifo #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Flush,
    input  logic              WrEn,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              RdEn,
    input  logic              ClrErr,
    output logic [DATA_W-1:0] DataOut,
    output logic              RdValid,
    output logic [ADDR_W:0]   Count,
    output logic              Full,
    output logic              Empty,
    output logic              AlmostFull,
    output logic              AlmostEmpty,
    output logic              Overflow,
    output logic              Underflow
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;
    logic              wr_ok;
    logic              rd_ok;
    logic              ovf_set;
    logic              unf_set;

    // Flush masks both requests so a flushing cycle neither moves data nor raises errors.
    assign wr_ok   = WrEn & ~Full  & ~Flush;
    assign rd_ok   = RdEn & ~Empty & ~Flush;
    assign ovf_set = WrEn & Full  & ~Flush;
    assign unf_set = RdEn & Empty & ~Flush;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; only entries already written are ever read.
    always_ff @(posedge Clk) begin
        if (wr_ok) mem[wr_ptr] <= DataIn;
    end

    // Read stage: one-cycle latency from an accepted read to DataOut/RdValid.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= rd_ok;
            if (rd_ok) data_p1 <= mem[rd_ptr];
        end
    end

    // A new error in the same cycle as ClrErr takes priority.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (ovf_set)     Overflow <= 1'b1;
            else if (ClrErr) Overflow <= 1'b0;
            if (unf_set)     Underflow <= 1'b1;
            else if (ClrErr) Underflow <= 1'b0;
        end
    end

    assign DataOut     = data_p1;
    assign RdValid     = vld_p1;
    assign Count       = count;
    assign Full        = (count == DEPTH_C);
    assign Empty       = (count == '0);
    assign AlmostFull  = (count >= AF_C);
    assign AlmostEmpty = (count <= AE_C);

endmodule

// File: tb/tb_cavlc_sync_fifo.sv
// Directed bench for cavlc_sync_fifo: a reference queue model predicts every output,
// and words read out are matched against a scoreboard of expected read data.
module tb_cavlc_sync_fifo;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        flush;
    logic        wr_en;
    logic [15:0] data_in;
    logic        rd_en;
    logic        clr_err;
    logic [15:0] data_out;
    logic        rd_valid;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] last_dout;
    logic        exp_rv;
    logic        m_ovf;
    logic        m_unf;

    cavlc_sync_fifo #(
        .DATA_W(16), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2)
    ) dut (
        .Clk(clk), .nReset(n_reset), .Flush(flush), .WrEn(wr_en), .DataIn(data_in),
        .RdEn(rd_en), .ClrErr(clr_err), .DataOut(data_out), .RdValid(rd_valid),
        .Count(count), .Full(full), .Empty(empty), .AlmostFull(almost_full),
        .AlmostEmpty(almost_empty), .Overflow(overflow), .Underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mem_q.size();
        chk({tag, ".rdvalid"}, 32'(rd_valid), 32'(exp_rv));
        if (exp_rv && exp_q.size() > 0) last_dout = exp_q.pop_front();
        chk({tag, ".dataout"}, 32'(data_out), 32'(last_dout));
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".full"}, 32'(full), 32'(n == 8));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(n >= 6));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 2));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    // Entered just after a falling edge; drives one cycle, then checks at the next falling edge.
    task automatic cyc(input string tag, input logic wr, input logic [15:0] d,
                       input logic rd, input logic fl, input logic clr);
        logic full_m;
        logic empty_m;
        wr_en   = wr;
        data_in = d;
        rd_en   = rd;
        flush   = fl;
        clr_err = clr;
        full_m  = (mem_q.size() == 8);
        empty_m = (mem_q.size() == 0);
        m_ovf   = (wr & full_m & ~fl) | (m_ovf & ~clr);
        m_unf   = (rd & empty_m & ~fl) | (m_unf & ~clr);
        exp_rv  = 1'b0;
        if (fl) begin
            mem_q.delete();
        end else begin
            if (rd && !empty_m) begin
                exp_q.push_back(mem_q.pop_front());
                exp_rv = 1'b1;
            end
            if (wr && !full_m) mem_q.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        mem_q.delete();
        exp_q.delete();
        last_dout = 16'h0000;
        exp_rv    = 1'b0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
    endtask

    initial begin
        n_reset = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        data_in = 16'h0000;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_reset = 1'b1;

        cyc("idle0", 0, 16'h0, 0, 0, 0);
        cyc("idle1", 0, 16'h0, 0, 0, 0);

        for (int i = 0; i < 8; i++) cyc("fill", 1, 16'hA000 + 16'(i), 0, 0, 0);
        cyc("ovf_wr", 1, 16'hBEEF, 0, 0, 0);

        for (int i = 0; i < 8; i++) cyc("drain", 0, 16'h0, 1, 0, 0);
        cyc("drain_tail", 0, 16'h0, 0, 0, 0);
        cyc("unf_rd", 0, 16'h0, 1, 0, 0);
        cyc("unf_idle", 0, 16'h0, 0, 0, 0);

        for (int i = 0; i < 3; i++) cyc("pre3", 1, 16'hC000 + 16'(i), 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc("wrap_rw", 1, 16'hD000 + 16'(i), 1, 0, 0);
        cyc("wrap_tail", 0, 16'h0, 0, 0, 0);

        for (int i = 0; i < 5; i++) cyc("refill", 1, 16'hE000 + 16'(i), 0, 0, 0);
        cyc("full_rw", 1, 16'hF00D, 1, 0, 0);
        cyc("full_rw_tail", 0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc("drain2", 0, 16'h0, 1, 0, 0);
        cyc("empty_rw", 1, 16'h1234, 1, 0, 0);
        cyc("empty_rw_tail", 0, 16'h0, 0, 0, 0);

        for (int i = 0; i < 4; i++) cyc("to5", 1, 16'h5000 + 16'(i), 0, 0, 0);
        cyc("flush_rw", 1, 16'h9999, 1, 1, 0);
        cyc("flush_tail", 0, 16'h0, 0, 0, 0);
        cyc("clr_err", 0, 16'h0, 0, 0, 1);
        cyc("flush_rd_empty", 0, 16'h0, 1, 1, 0);
        cyc("clr_vs_new", 0, 16'h0, 1, 0, 1);
        cyc("clr_err2", 0, 16'h0, 0, 0, 1);

        for (int i = 0; i < 4; i++) cyc("burst", 1, 16'h7000 + 16'(i), 0, 0, 0);
        wr_en   = 1'b1;
        data_in = 16'h7777;
        rd_en   = 1'b1;
        #2;
        n_reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        check_all("rst_held");
        n_reset = 1'b1;
        cyc("post_rst", 0, 16'h0, 0, 0, 0);
        cyc("post_rst_wr", 1, 16'h4242, 0, 0, 0);
        cyc("post_rst_rd", 0, 16'h0, 1, 0, 0);
        cyc("post_rst_tail", 0, 16'h0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
